// File: rtl/uart_tx_arbiter_if.sv
// rtl/uart_tx_arbiter_if.sv - requester and UART transmitter handshake bundle for uart_tx_arbiter
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4
) ();
  logic [NUM_REQ-1:0]   i_req_valid;
  logic [8*NUM_REQ-1:0] i_req_data;
  logic [NUM_REQ-1:0]   i_req_last;
  logic [NUM_REQ-1:0]   o_req_ready;
  logic [7:0]           o_tx_data;
  logic                 o_tx_valid;
  logic                 i_tx_ready;

  // slave is the arbiter side, master is the requesters plus transmitter side
  modport slave (
    input  i_req_valid, i_req_data, i_req_last, i_tx_ready,
    output o_req_ready, o_tx_data, o_tx_valid
  );

  modport master (
    output i_req_valid, i_req_data, i_req_last, i_tx_ready,
    input  o_req_ready, o_tx_data, o_tx_valid
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin frame arbiter sharing one UART transmitter with stall timeout
module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int TIMEOUT_CLKS = 1024
) (
  input  logic                       i_clk,
  input  logic                       i_rst,
  uart_tx_arbiter_if.slave           bus,
  output logic [$clog2(NUM_REQ)-1:0] o_grant,
  output logic                       o_busy,
  output logic                       o_timeout
);
  localparam int GW = $clog2(NUM_REQ);
  localparam int SW = (TIMEOUT_CLKS > 0) ? $clog2(TIMEOUT_CLKS + 1) : 1;

  typedef enum logic {IDLE, GRANT} state_t;

  state_t        state;
  logic [GW-1:0] rr_ptr;
  logic [GW-1:0] pick;
  logic [GW-1:0] next_ptr;
  logic          pick_found;
  logic [SW-1:0] stall_cnt;
  logic          own_valid;
  logic          own_last;
  logic          xfer;
  logic          stall_expired;

  // first valid requester at or above rr_ptr, wrapping past NUM_REQ-1
  always_comb begin
    logic [GW:0]   sum;
    logic [GW-1:0] idx;
    sum        = '0;
    idx        = '0;
    pick       = '0;
    pick_found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      sum = {1'b0, rr_ptr} + (GW+1)'(i);
      if (sum >= (GW+1)'(NUM_REQ)) begin
        sum = sum - (GW+1)'(NUM_REQ);
      end
      idx = sum[GW-1:0];
      if (!pick_found && bus.i_req_valid[idx]) begin
        pick_found = 1'b1;
        pick       = idx;
      end
    end
  end

  assign next_ptr      = (o_grant == GW'(NUM_REQ - 1)) ? '0 : o_grant + GW'(1);
  assign own_valid     = bus.i_req_valid[o_grant];
  assign own_last      = bus.i_req_last[o_grant];
  assign xfer          = (state == GRANT) && own_valid && bus.i_tx_ready;
  // fires on the stall cycle that would bring the count to TIMEOUT_CLKS
  assign stall_expired = (TIMEOUT_CLKS > 0) && (stall_cnt == SW'(TIMEOUT_CLKS - 1));

  always_comb begin
    bus.o_tx_data   = '0;
    bus.o_tx_valid  = 1'b0;
    bus.o_req_ready = '0;
    if (state == GRANT) begin
      bus.o_tx_data            = bus.i_req_data[{o_grant, 3'b000} +: 8];
      bus.o_tx_valid           = own_valid;
      bus.o_req_ready[o_grant] = bus.i_tx_ready;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state     <= IDLE;
      rr_ptr    <= '0;
      o_grant   <= '0;
      o_busy    <= 1'b0;
      o_timeout <= 1'b0;
      stall_cnt <= '0;
    end else begin
      o_timeout <= 1'b0;
      case (state)
        IDLE: begin
          stall_cnt <= '0;
          if (pick_found) begin
            state   <= GRANT;
            o_grant <= pick;
            o_busy  <= 1'b1;
          end
        end
        GRANT: begin
          if (xfer) begin
            stall_cnt <= '0;
            if (own_last) begin
              state  <= IDLE;
              o_busy <= 1'b0;
              rr_ptr <= next_ptr;
            end
          end else if (!own_valid) begin
            if (stall_expired) begin
              state     <= IDLE;
              o_busy    <= 1'b0;
              o_timeout <= 1'b1;
              rr_ptr    <= next_ptr;
              stall_cnt <= '0;
            end else if (TIMEOUT_CLKS > 0) begin
              stall_cnt <= stall_cnt + SW'(1);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;
  localparam int NUM_REQ      = 4;
  localparam int TIMEOUT_CLKS = 8;

  typedef struct packed { logic [7:0] data; logic last; } beat_t;
  typedef struct packed { logic [1:0] src; logic [7:0] data; logic last; } exp_t;
  typedef struct { int pre; int len; int mode; logic [7:0] base; int n; logic [7:0] ord; } vec_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] grant;
  logic       busy;
  logic       timeout;
  int         n_checks = 0;
  int         n_errors = 0;
  int         tx_mode = 1;
  logic       pulse_ph = 1'b0;
  logic       last_seen = 1'b0;
  beat_t      src_q [NUM_REQ][$];
  exp_t       exp_q [$];

  uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ)) bus ();

  uart_tx_arbiter #(.NUM_REQ(NUM_REQ), .TIMEOUT_CLKS(TIMEOUT_CLKS)) dut (
    .i_clk(clk), .i_rst(rst), .bus(bus),
    .o_grant(grant), .o_busy(busy), .o_timeout(timeout)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] fdata(int k, int i, logic [7:0] base);
    return base + 8'(k * 16 + i);
  endfunction

  function automatic bit all_empty();
    for (int k = 0; k < NUM_REQ; k++) if (src_q[k].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  task automatic add_frame(int k, int len, logic [7:0] base);
    for (int i = 0; i < len; i++) src_q[k].push_back({fdata(k, i, base), 1'(i == len - 1)});
  endtask

  task automatic expect_frame(int k, int len, logic [7:0] base);
    for (int i = 0; i < len; i++) exp_q.push_back({2'(k), fdata(k, i, base), 1'(i == len - 1)});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    for (int k = 0; k < NUM_REQ; k++) src_q[k].delete();
    exp_q.delete();
    last_seen = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    #1;
  endtask

  task automatic wait_drain(string name, int budget);
    int c = 0;
    while (c < budget && !(exp_q.size() == 0 && all_empty() && !busy)) begin
      @(negedge clk);
      #1;
      c++;
    end
    check(name, {31'd0, exp_q.size() == 0 && all_empty() && !busy}, 32'd1);
  endtask

  task automatic wait_busy(string name, int budget);
    int c = 0;
    while (c < budget && !busy) begin
      @(negedge clk);
      #1;
      c++;
    end
    check(name, {31'd0, busy}, 32'd1);
  endtask

  task automatic wait_src_size(string name, int k, int size, int budget);
    int c = 0;
    while (c < budget && src_q[k].size() != size) begin
      @(negedge clk);
      #1;
      c++;
    end
    check(name, src_q[k].size(), size);
  endtask

  // requester and transmitter models: present queue heads, shape tx_ready per mode
  initial begin
    bus.i_req_valid = '0;
    bus.i_req_data  = '0;
    bus.i_req_last  = '0;
    bus.i_tx_ready  = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NUM_REQ; k++) begin
        if (src_q[k].size() != 0) begin
          bus.i_req_valid[k]        = 1'b1;
          bus.i_req_data[8*k +: 8]  = src_q[k][0].data;
          bus.i_req_last[k]         = src_q[k][0].last;
        end else begin
          bus.i_req_valid[k] = 1'b0;
          bus.i_req_last[k]  = 1'b0;
        end
      end
      case (tx_mode)
        0: bus.i_tx_ready = 1'b0;
        1: bus.i_tx_ready = 1'b1;
        2: begin
          pulse_ph       = ~pulse_ph;
          bus.i_tx_ready = pulse_ph;
        end
        default: bus.i_tx_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // scoreboard: every transferred byte is popped against the expected queue
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst !== 1'b0) begin
        last_seen = 1'b0;
      end else begin
        if (last_seen) begin
          check("busy_after_last", {31'd0, busy}, 32'd0);
          last_seen = 1'b0;
        end
        if (!busy) begin
          check("idle_tx_valid", {31'd0, bus.o_tx_valid}, 32'd0);
          check("idle_req_ready", {28'd0, bus.o_req_ready}, 32'd0);
        end
        if (bus.o_tx_valid && bus.i_tx_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_byte: got %0h from %0d expected no transfer", bus.o_tx_data, grant);
          end else begin
            e = exp_q.pop_front();
            check("tx_data", {24'd0, bus.o_tx_data}, {24'd0, e.data});
            check("tx_src", {30'd0, grant}, {30'd0, e.src});
            last_seen = e.last;
          end
        end
        for (int k = 0; k < NUM_REQ; k++)
          if (bus.i_req_valid[k] && bus.o_req_ready[k]) void'(src_q[k].pop_front());
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t tbl [5];
    int   k;
    logic bp_bad;
    tbl[0] = '{pre: -1, len: 2, mode: 1, base: 8'h00, n: 3, ord: 8'h34};
    tbl[1] = '{pre:  2, len: 3, mode: 2, base: 8'h21, n: 4, ord: 8'h93};
    tbl[2] = '{pre:  1, len: 1, mode: 1, base: 8'h60, n: 2, ord: 8'h04};
    tbl[3] = '{pre:  3, len: 3, mode: 3, base: 8'h05, n: 2, ord: 8'h0E};
    tbl[4] = '{pre:  0, len: 2, mode: 2, base: 8'h88, n: 2, ord: 8'h02};

    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_grant", {30'd0, grant}, 32'd0);
    check("rst_timeout", {31'd0, timeout}, 32'd0);
    check("rst_tx_valid", {31'd0, bus.o_tx_valid}, 32'd0);
    check("rst_req_ready", {28'd0, bus.o_req_ready}, 32'd0);

    // optional lead-in frame sets rr_ptr, then all listed requesters start together
    for (int e = 0; e < 5; e++) begin
      do_reset();
      tx_mode = tbl[e].mode;
      if (tbl[e].pre >= 0) begin
        add_frame(tbl[e].pre, tbl[e].len, tbl[e].base);
        expect_frame(tbl[e].pre, tbl[e].len, tbl[e].base);
        wait_drain("pre_drain", 200);
      end
      for (int j = 0; j < tbl[e].n; j++) begin
        k = int'(tbl[e].ord[2*j +: 2]);
        add_frame(k, tbl[e].len, tbl[e].base + 8'h80);
        expect_frame(k, tbl[e].len, tbl[e].base + 8'h80);
      end
      wait_drain("table_drain", 400);
    end

    // fairness: requester 1 slots in right after requester 0's current frame
    do_reset();
    tx_mode = 2;
    add_frame(0, 4, 8'h10);
    add_frame(0, 2, 8'h40);
    add_frame(0, 2, 8'h50);
    expect_frame(0, 4, 8'h10);
    expect_frame(1, 2, 8'h20);
    expect_frame(0, 2, 8'h40);
    expect_frame(0, 2, 8'h50);
    wait_busy("fair_busy", 20);
    add_frame(1, 2, 8'h20);
    wait_drain("fair_drain", 300);

    // timeout: one non-last byte, then eight stall cycles
    do_reset();
    tx_mode = 1;
    add_frame(1, 1, 8'h55);
    src_q[1][0].last = 1'b0;
    exp_q.push_back({2'd1, fdata(1, 0, 8'h55), 1'b0});
    wait_src_size("to_first_byte", 1, 0, 20);
    for (int n = 1; n <= 10; n++) begin
      @(negedge clk);
      #1;
      check("to_pulse", {31'd0, timeout}, {31'd0, 1'(n == 9)});
      check("to_busy", {31'd0, busy}, {31'd0, 1'(n <= 8)});
    end
    check("to_exp_empty", exp_q.size(), 0);
    add_frame(1, 1, 8'h70);
    add_frame(2, 1, 8'h70);
    expect_frame(2, 1, 8'h70);
    expect_frame(1, 1, 8'h70);
    wait_drain("to_rr_drain", 100);

    // backpressure: owner valid, transmitter not ready for 50 cycles
    do_reset();
    tx_mode = 0;
    add_frame(0, 2, 8'hA0);
    expect_frame(0, 2, 8'hA0);
    wait_busy("bp_busy", 20);
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      #1;
      bp_bad = (bus.o_tx_data != 8'hA0) || !bus.o_tx_valid || timeout || !busy || (bus.o_req_ready != '0);
      check("bp_hold", {31'd0, bp_bad}, 32'd0);
    end
    tx_mode = 1;
    wait_drain("bp_drain", 50);

    // reset while byte 2 of 4 is on the bus
    do_reset();
    tx_mode = 1;
    add_frame(0, 4, 8'hC0);
    exp_q.push_back({2'd0, fdata(0, 0, 8'hC0), 1'b0});
    wait_src_size("rm_first_byte", 0, 3, 20);
    @(posedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    #1;
    src_q[0].delete();
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    #1;
    check("rm_busy", {31'd0, busy}, 32'd0);
    check("rm_tx_valid", {31'd0, bus.o_tx_valid}, 32'd0);
    check("rm_req_ready", {28'd0, bus.o_req_ready}, 32'd0);
    check("rm_exp_empty", exp_q.size(), 0);
    add_frame(0, 2, 8'hD0);
    expect_frame(0, 2, 8'hD0);
    wait_drain("rm_after_drain", 50);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of requesters sharing one UART transmitter, range 2..8.
REQ-002 SHALL have parameter TIMEOUT_CLKS, default 1024: idle-stall cycles before a mid-frame grant is revoked; 0 disables the timeout.
REQ-003 SHALL have port i_clk  input  1  sole clock; all state changes on its rising edge.
REQ-004 SHALL have port i_rst  input  1  synchronous, active-high reset.
REQ-005 SHALL have port i_req_valid  input  NUM_REQ  per-requester byte valid.
REQ-006 SHALL have port i_req_data  input  8*NUM_REQ  per-requester byte; requester k at bits [8k+7:8k].
REQ-007 SHALL have port i_req_last  input  NUM_REQ  marks the final byte of requester's frame.
REQ-008 SHALL have port o_req_ready  output  NUM_REQ  per-requester byte accept.
REQ-009 SHALL have port o_tx_data  output  8  byte to the UART transmitter.
REQ-010 SHALL have port o_tx_valid  output  1  byte valid to the UART transmitter.
REQ-011 SHALL have port i_tx_ready  input  1  UART transmitter idle (ready) flag.
REQ-012 SHALL have port o_grant  output  $clog2(NUM_REQ)  index of current owner; meaningful only when o_busy=1.
REQ-013 SHALL have port o_busy  output  1  high while a requester holds the grant.
REQ-014 SHALL have port o_timeout  output  1  one-cycle pulse when a grant is revoked by timeout.

Function
REQ-015 SHALL implement a two-state FSM: IDLE, GRANT.
REQ-016 In IDLE, SHALL select the first requester with i_req_valid=1 searching upward from round-robin pointer rr_ptr with wrap at NUM_REQ-1 -> 0.
REQ-017 SHALL register the selection: o_grant and o_busy update, and state becomes GRANT, one cycle after a valid is seen in IDLE (1-cycle arbitration latency).
REQ-018 In IDLE, o_tx_valid SHALL be 0 and o_req_ready SHALL be all zeros.
REQ-019 In GRANT with owner g: o_tx_data = i_req_data[g], o_tx_valid = i_req_valid[g], o_req_ready[g] = i_tx_ready, all other o_req_ready bits 0 (combinational).
REQ-020 A byte transfer SHALL occur on a cycle with o_tx_valid=1 and i_tx_ready=1 in GRANT.
REQ-021 A transfer with i_req_last[g]=1 SHALL return the FSM to IDLE next cycle and set rr_ptr to (g+1) mod NUM_REQ.
REQ-022 A transfer with i_req_last[g]=0 SHALL keep the grant; the grant SHALL never move between requesters mid-frame except by timeout.
REQ-023 Valid requests from non-owners SHALL be ignored (held pending) while in GRANT.
REQ-024 Stall counter (width $clog2(TIMEOUT_CLKS+1)) SHALL clear on entry to GRANT and on every transfer, and increment on each GRANT cycle with i_req_valid[g]=0.
REQ-025 Cycles with i_req_valid[g]=1 and i_tx_ready=0 SHALL neither increment nor clear the stall counter.
REQ-026 When the stall counter reaches TIMEOUT_CLKS (TIMEOUT_CLKS>0), SHALL go to IDLE, pulse o_timeout for one cycle, set rr_ptr to (g+1) mod NUM_REQ.
REQ-027 If a timeout and a transfer coincide, the transfer SHALL take precedence and the timeout SHALL not fire.
REQ-028 After returning to IDLE, SHALL spend at least one cycle in IDLE before the next grant (no back-to-back GRANT).
REQ-029 Each byte SHALL be passed to the transmitter exactly once; no byte duplication or loss.

Reset
REQ-030 On i_rst=1 at a clock edge: state IDLE, rr_ptr 0, o_grant 0, o_busy 0, o_timeout 0, stall counter 0.
REQ-031 Reset asserted mid-frame SHALL abandon the frame; o_tx_valid and all o_req_ready SHALL be 0 from the cycle after reset is sampled.
REQ-032 Reset SHALL take precedence over all other events in the same cycle.

Verification
REQ-033 Single frame: requester 2 sends 0x41,0x42,0x43 (last on 0x43) with i_tx_ready pulsing -> bytes appear on o_tx_data in order, o_busy falls after 0x43, rr_ptr=3.
REQ-034 Contention: requesters 0,1,3 all valid at reset release with 2-byte frames -> grants in order 0,1,3, each frame contiguous.
REQ-035 Fairness: requester 0 continuously requests, requester 1 requests once -> requester 1 granted immediately after requester 0's current frame.
REQ-036 Timeout: TIMEOUT_CLKS=8, requester 1 sends one non-last byte then drops valid -> o_timeout pulses 8 stall cycles later, FSM IDLE, rr_ptr=2.
REQ-037 Backpressure: i_tx_ready low for 50 cycles while owner valid -> no timeout, no transfer, data held stable.
REQ-038 Reset mid-frame: i_rst during byte 2 of 4 -> o_busy=0, o_tx_valid=0 next cycle; subsequent request from requester 0 granted normally.
